// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic SEL_IN0    = 1'b0;
    localparam logic SEL_IN1    = 1'b1;
    localparam int   DEF_WIDTH  = 32;
    localparam int   CNT_W      = 16;

endpackage

// File: rtl/mux.sv
// Existing 2:1 datapath mux; control=0 passes in0, control=1 passes in1.
module mux #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             control,
    output logic [WIDTH-1:0] out
);

    // Plain select, no registering.
    always_comb begin
        out = control ? in1 : in0;
    end

endmodule

// File: rtl/mux_arbiter2_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick,
    output logic any_req
);

    // pick is only meaningful when any_req is high.
    always_comb begin
        any_req = req0 | req1;
        pick    = (req0 && req1) ? ~last : req1;
    end

endmodule

// File: rtl/mux_arbiter2.sv
// Round-robin arbiter sharing one mux between two producers, with a single
// registered output stage and valid/ready handshake.
// Optional grant counters (cnt0/cnt1) are built when MUX_ARB_CNT_EN is defined.
//
//   state | meaning
//   IDLE  | output stage empty, out_valid=0
//   FULL  | out_data holds an unconsumed word, out_valid=1
module mux_arbiter2
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef MUX_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    state_t           state_q, state_d;
    logic             last_q;
    logic             sel_q;
    logic             pick;
    logic             any_req;
    logic             load;
    logic [WIDTH-1:0] mux_out;

    rr_pick2 u_pick (
        .req0    (req0),
        .req1    (req1),
        .last    (last_q),
        .pick    (pick),
        .any_req (any_req)
    );

    mux #(.WIDTH(WIDTH)) u_mux (
        .in0     (data0),
        .in1     (data1),
        .control (sel),
        .out     (mux_out)
    );

    assign load      = any_req && ((state_q == IDLE) || out_ready);
    assign out_valid = (state_q == FULL);

    // Next state, grants and mux select; sel holds whenever nothing loads.
    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        sel     = sel_q;
        if (load) begin
            sel     = pick;
            gnt0    = (pick == SEL_IN0);
            gnt1    = (pick == SEL_IN1);
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Output word, last winner and held select; last=1 lets requester 0 win first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            last_q   <= 1'b1;
            sel_q    <= SEL_IN0;
        end else begin
            sel_q <= sel;
            if (load) begin
                out_data <= mux_out;
                last_q   <= pick;
            end
        end
    end

`ifdef MUX_ARB_CNT_EN
    // Saturating per-requester grant counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (gnt0 && (cnt0 != {CNT_W{1'b1}})) cnt0 <= cnt0 + 1'b1;
            if (gnt1 && (cnt1 != {CNT_W{1'b1}})) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_arbiter2.sv
// Self-checking bench for mux_arbiter2: directed table, hand sequences for
// reset/backpressure corners, and a randomized run against a behavioural model.
module tb_mux_arbiter2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
    logic [31:0] data0 = '0, data1 = '0;
    logic        gnt0, gnt1, sel, out_valid;
    logic [31:0] out_data;
`ifdef MUX_ARB_CNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_arbiter2 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .data1     (data1),
        .gnt1      (gnt1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef MUX_ARB_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    typedef struct {
        logic        r0;
        logic        r1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        rdy;
        logic        g0;
        logic        g1;
        logic        s;
        logic        v;
        logic [31:0] q;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic [31:0] d0,
                         input logic [31:0] d1, input logic rdy);
        req0      = r0;
        req1      = r1;
        data0     = d0;
        data1     = d1;
        out_ready = rdy;
    endtask

    function automatic vec_t mk(input logic r0, input logic r1, input logic [31:0] d0,
                                input logic [31:0] d1, input logic rdy, input logic g0,
                                input logic g1, input logic s, input logic v,
                                input logic [31:0] q);
        vec_t t;
        t.r0 = r0; t.r1 = r1; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
        t.g0 = g0; t.g1 = g1; t.s = s; t.v = v; t.q = q;
        return t;
    endfunction

    // Reset pulse ending just after a rising edge; leaves the bench at posedge+1.
    task automatic do_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Behavioural reference state for the random phase.
    logic        m_valid;
    logic [31:0] m_data;
    int          m_last;
    logic        m_sel;
    int          m_cnt[2];

    initial begin
        logic r0, r1, rdy, eg0, eg1;
        logic [31:0] d0, d1;
        int winner;

        // Reset state, checked while reset is still held.
        #2;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_sel", {31'b0, sel}, 32'd0);
        check("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // First single grant: gnt same cycle, data one cycle later.
        drive(1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0, 1'b1);
        @(negedge clk);
        check("first_gnt0", {31'b0, gnt0}, 32'd1);
        check("first_gnt1", {31'b0, gnt1}, 32'd0);
        check("first_sel", {31'b0, sel}, 32'd0);
        @(posedge clk);
        #1;
        check("first_valid", {31'b0, out_valid}, 32'd1);
        check("first_data", out_data, 32'hAAAA_AAAA);

        // Directed table, starting from a fresh reset (last=1).
        for (int i = 0; i < 6; i++)
            tbl[i] = mk(1, 1, 32'h1234_5678, 32'h8765_4321, 1, (i % 2) == 0, (i % 2) == 1,
                        (i % 2) == 1, 1, ((i % 2) == 0) ? 32'h1234_5678 : 32'h8765_4321);
        for (int i = 6; i < 9; i++)
            tbl[i] = mk(0, 1, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 1, 1, 32'h8765_4321);
        tbl[9]  = mk(0, 1, 32'h0, 32'hCAFE_F00D, 1, 0, 1, 1, 1, 32'hCAFE_F00D);
        tbl[10] = mk(1, 0, 32'h0BAD_BEEF, 32'h0, 1, 1, 0, 0, 1, 32'h0BAD_BEEF);
        tbl[11] = mk(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 32'h0BAD_BEEF);
        tbl[12] = mk(0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 32'h0BAD_BEEF);
        tbl[13] = mk(0, 1, 32'h0, 32'h1111_1111, 0, 0, 1, 1, 1, 32'h1111_1111);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1, tbl[i].rdy);
            @(negedge clk);
            check($sformatf("tbl%0d_gnt0", i), {31'b0, gnt0}, {31'b0, tbl[i].g0});
            check($sformatf("tbl%0d_gnt1", i), {31'b0, gnt1}, {31'b0, tbl[i].g1});
            check($sformatf("tbl%0d_sel", i), {31'b0, sel}, {31'b0, tbl[i].s});
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].v});
            check($sformatf("tbl%0d_data", i), out_data, tbl[i].q);
`ifdef MUX_ARB_CNT_EN
            if (i == 5) begin
                check("cnt0_alt", {16'b0, cnt0}, 32'd3);
                check("cnt1_alt", {16'b0, cnt1}, 32'd3);
            end
`endif
        end

        // Reset while FULL with last=0: out_valid clears without an edge.
        drive(1'b1, 1'b0, 32'h0BAD_F00D, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_data", out_data, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 1'b1, 32'h5555_0000, 32'h0000_5555, 1'b1);
        @(negedge clk);
        check("post_rst_gnt0", {31'b0, gnt0}, 32'd1);
        check("post_rst_gnt1", {31'b0, gnt1}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_2nd_gnt1", {31'b0, gnt1}, 32'd1);
        @(posedge clk);
        #1;
        check("post_rst_2nd_data", out_data, 32'h0000_5555);

`ifdef MUX_ARB_CNT_EN
        // Saturation: preload cnt0 to all ones, then grant requester 0 again.
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        force dut.cnt0 = 16'hFFFF;
        #1 release dut.cnt0;
        drive(1'b1, 1'b0, 32'h1, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check("cnt0_sat", {16'b0, cnt0}, 32'h0000_FFFF);
`endif

        // Randomized run against the behavioural model.
        do_reset();
        m_valid = 1'b0; m_data = '0; m_last = 1; m_sel = 1'b0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        for (int n = 0; n < 400; n++) begin
            r0  = 1'($urandom_range(0, 1));
            r1  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            d0  = $urandom;
            d1  = $urandom;
            drive(r0, r1, d0, d1, rdy);
            eg0 = 1'b0;
            eg1 = 1'b0;
            if ((r0 || r1) && (!m_valid || rdy)) begin
                if (r0 && r1) winner = 1 - m_last;
                else          winner = r1 ? 1 : 0;
                eg0      = (winner == 0);
                eg1      = (winner == 1);
                m_sel    = (winner == 1);
                m_data   = (winner == 1) ? d1 : d0;
                m_valid  = 1'b1;
                m_last   = winner;
                if (m_cnt[winner] < 65535) m_cnt[winner]++;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
            check("rnd_gnt0", {31'b0, gnt0}, {31'b0, eg0});
            check("rnd_gnt1", {31'b0, gnt1}, {31'b0, eg1});
            check("rnd_sel", {31'b0, sel}, {31'b0, m_sel});
            @(posedge clk);
            #1;
            check("rnd_valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("rnd_data", out_data, m_data);
        end
`ifdef MUX_ARB_CNT_EN
        check("rnd_cnt0", {16'b0, cnt0}, m_cnt[0]);
        check("rnd_cnt1", {16'b0, cnt1}, m_cnt[1]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
